// File: rtl/gate_op_pkg.sv
// Shared types and constants for the gate operation scheduler.
package gate_op_pkg;

    localparam int unsigned OP_W       = 3;
    localparam int unsigned OP_COUNT_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_XOR     = 3'd2,
        OP_NAND    = 3'd3,
        OP_NOR     = 3'd4,
        OP_XNOR    = 3'd5,
        OP_ANOTB   = 3'd6,
        OP_ILLEGAL = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fsm_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [OP_COUNT_W-1:0] sat_inc(input logic [OP_COUNT_W-1:0] v);
        return (v == '1) ? v : v + OP_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/gate_op_alu.sv
// Combinational 2-input bitwise logic unit; opcode 7 flags an error and yields zero.
module gate_op_alu
    import gate_op_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  gate_op_e         op,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    // Operation decode; inversions cover the full operand width.
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XNOR:  y = ~(a ^ b);
            OP_ANOTB: y = a & ~b;
            default: begin
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one bitwise logic unit among NUM_REQ requesters,
// one operation in flight, valid/ready on both the request and response sides.
module gate_op_scheduler
    import gate_op_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*WIDTH-1:0]    req_b,
    input  logic [NUM_REQ*OP_W-1:0]     req_op,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WIDTH-1:0]            rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic                        rsp_err,
    output logic [OP_COUNT_W-1:0]       op_count
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    fsm_state_e             state_q;
    logic [IDW-1:0]         rr_ptr_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    gate_op_e               op_q;
    logic [IDW-1:0]         id_q;
    logic [OP_COUNT_W-1:0]  op_count_q;

    logic [WIDTH-1:0]       a_arr  [NUM_REQ];
    logic [WIDTH-1:0]       b_arr  [NUM_REQ];
    gate_op_e               op_arr [NUM_REQ];

    logic                   grant_found;
    logic [IDW-1:0]         grant_idx;
    logic [IDW-1:0]         scan_idx;
    logic [WIDTH-1:0]       alu_y;
    logic                   alu_err;

    // Unpack the flat per-requester buses.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g]  = req_b[g*WIDTH +: WIDTH];
        assign op_arr[g] = gate_op_e'(req_op[g*OP_W +: OP_W]);
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // One-hot accept, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (!reset && state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    gate_op_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .y   (alu_y),
        .err (alu_err)
    );

    assign op_count = op_count_q;

    // Control FSM with operand capture, response registers and completion counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_AND;
            id_q       <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            op_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        a_q      <= a_arr[grant_idx];
                        b_q      <= b_arr[grant_idx];
                        op_q     <= op_arr[grant_idx];
                        id_q     <= grant_idx;
                        rr_ptr_q <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_y;
                    rsp_err   <= alu_err;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state_q   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        op_count_q <= sat_inc(op_count_q);
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed and randomized bench for gate_op_scheduler against a truth-table model.
`timescale 1ns/1ps
module tb_gate_op_scheduler;

    localparam int NR = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic [NR*3-1:0] req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_data;
    logic [1:0]      rsp_id;
    logic            rsp_err;
    logic [15:0]     op_count;

    gate_op_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    int          m_ptr;
    int          m_count;
    int          last_hs;
    bit          back_to_back;
    logic [W-1:0] ta  [NR];
    logic [W-1:0] tbv [NR];
    logic [2:0]   top [NR];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-bit truth table indexed by {a,b}; opcode 7 is an error with zero data.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
        logic [3:0]   lut;
        logic [W-1:0] y;
        lut = 4'b0000;
        y   = '0;
        case (op)
            3'd0: lut = 4'b1000;
            3'd1: lut = 4'b1110;
            3'd2: lut = 4'b0110;
            3'd3: lut = 4'b0111;
            3'd4: lut = 4'b0001;
            3'd5: lut = 4'b1001;
            3'd6: lut = 4'b0100;
            default: return {1'b1, {W{1'b0}}};
        endcase
        for (int i = 0; i < W; i++) y[i] = lut[{a[i], b[i]}];
        return {1'b0, y};
    endfunction

    function automatic int model_grant(input logic [NR-1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return 0;
    endfunction

    task automatic drive_inputs(input logic [NR-1:0] mask);
        req_valid = mask;
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W]  = ta[i];
            req_b[i*W +: W]  = tbv[i];
            req_op[i*3 +: 3] = top[i];
        end
    endtask

    // One full transaction, entered just after a falling edge with the DUT idle.
    task automatic run_op(input logic [NR-1:0] mask, input int stall, input string tag);
        int         g;
        logic [W:0] exp;
        rsp_ready = 1'b0;
        drive_inputs(mask);
        #1;
        g   = model_grant(mask, m_ptr);
        exp = ref_op(ta[g], tbv[g], top[g]);
        check({tag, " grant"}, 32'(req_ready), 32'(1) << g);
        if (back_to_back) check({tag, " gap"}, 32'(cyc - last_hs), 32'd3);
        last_hs = cyc;
        m_ptr   = (g + 1) % NR;
        @(negedge clk);
        check({tag, " exec_ready"}, 32'(req_ready), 32'd0);
        check({tag, " exec_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_data"},  32'(rsp_data),  32'(exp[W-1:0]));
        check({tag, " rsp_id"},    32'(rsp_id),    32'(g));
        check({tag, " rsp_err"},   32'(rsp_err),   32'(exp[W]));
        check({tag, " resp_ready"}, 32'(req_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hold_data"},  32'(rsp_data),  32'(exp[W-1:0]));
            check({tag, " hold_id"},    32'(rsp_id),    32'(g));
            check({tag, " hold_err"},   32'(rsp_err),   32'(exp[W]));
            check({tag, " hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, " hold_count"}, 32'(op_count),  32'(m_count));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (m_count < 65535) m_count++;
        check({tag, " done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " done_count"}, 32'(op_count),  32'(m_count));
        check({tag, " next_grant"}, 32'(req_ready), 32'(1) << model_grant(mask, m_ptr));
        back_to_back = (stall == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        req_op       = '0;
        rsp_ready    = 1'b0;
        m_ptr        = 0;
        m_count      = 0;
        last_hs      = 0;
        back_to_back = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ta[i] = '0; tbv[i] = '0; top[i] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data",  32'(rsp_data),  32'd0);
        check("reset rsp_id",    32'(rsp_id),    32'd0);
        check("reset rsp_err",   32'(rsp_err),   32'd0);
        check("reset op_count",  32'(op_count),  32'd0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single AND on requester 0
        ta[0] = 8'hF0; tbv[0] = 8'hCC; top[0] = 3'd0;
        run_op(4'b0001, 0, "single");

        // Every opcode on requester 2
        for (int op = 0; op < 8; op++) begin
            ta[2] = 8'hF0; tbv[2] = 8'hCC; top[2] = 3'(op);
            back_to_back = 1'b0;
            run_op(4'b0100, 0, $sformatf("allops%0d", op));
        end

        // Backpressure with all requesters waiting
        for (int i = 0; i < NR; i++) begin
            ta[i] = 8'(8'h11 * (i + 1)); tbv[i] = 8'h5A; top[i] = 3'(i);
        end
        back_to_back = 1'b0;
        run_op(4'b1111, 5, "backpressure");

        // Reset while an op is executing
        req_valid = '0;
        @(negedge clk);
        drive_inputs(4'b1111);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_exec rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec req_ready", 32'(req_ready), 32'd0);
        check("rst_exec rsp_data",  32'(rsp_data),  32'd0);
        check("rst_exec op_count",  32'(op_count),  32'd0);
        req_valid = '0;
        @(negedge clk);
        reset   = 1'b0;
        m_ptr   = 0;
        m_count = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_exec no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Round-robin, all valid, response always accepted
        back_to_back = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run_op(4'b1111, 0, $sformatf("rr%0d", k));
        end

        // Randomized traffic
        back_to_back = 1'b0;
        for (int k = 0; k < 250; k++) begin
            for (int i = 0; i < NR; i++) begin
                ta[i]  = 8'($urandom);
                tbv[i] = 8'($urandom);
                top[i] = 3'($urandom_range(0, 7));
            end
            run_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
        end

        // Counter saturation near the top of range
        req_valid = '0;
        @(negedge clk);
        force dut.op_count_q = 16'hFFFD;
        @(negedge clk);
        release dut.op_count_q;
        m_count = 65533;
        @(negedge clk);
        check("sat preload", 32'(op_count), 32'h0000FFFD);
        back_to_back = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ta[1] = 8'($urandom); tbv[1] = 8'($urandom); top[1] = 3'(k);
            run_op(4'b0010, 0, $sformatf("sat%0d", k));
        end
        check("sat final", 32'(op_count), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
